wta_seq_predictor_n: RTL and testbench

WTA_SEQ_PREDICTOR_N -- requirements
Module: wta_seq_predictor_n

---
 rtl/pst_pkg.sv | 34 +++
 rtl/pst_circ_stepper.sv | 41 ++++
 rtl/wta_seq_predictor_n.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_wta_seq_predictor_n.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pst_pkg.sv
// Shared types and helpers for the winner-take-all sequence predictor.
package pst_pkg;

    // Controller states: distance scan, learn, prediction scan, result.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DSCAN = 3'd1,
        ST_LEARN = 3'd2,
        ST_PSCAN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Working width of the distance helper; phase widths up to this are supported.
    localparam int CALC_W       = 32;
    // Default phase (distance) width and sequence-weight width.
    localparam int PHASE_W_DEF  = 8;
    localparam int WEIGHT_W_DEF = 8;

    // Shortest circular distance between a and b on a ring of 2^width points.
    function automatic logic [CALC_W-1:0] circ_dist(
        input logic [CALC_W-1:0] a,
        input logic [CALC_W-1:0] b,
        input int                width
    );
        logic [CALC_W-1:0] mask;
        logic [CALC_W-1:0] fwd;
        logic [CALC_W-1:0] bwd;
        mask = (width >= CALC_W) ? '1 : ((CALC_W'(1) << width) - CALC_W'(1));
        fwd  = (a - b) & mask;
        bwd  = (b - a) & mask;
        return (fwd < bwd) ? fwd : bwd;
    endfunction

endpackage

// File: rtl/pst_circ_stepper.sv
// Combinational slot mover: distance, shortest direction and wrapped step
// from the current slot phase toward the observed phase.
module pst_circ_stepper
    import pst_pkg::*;
#(
    parameter int PW       = PHASE_W_DEF,
    parameter int STEP_SH  = 2,
    parameter int DEADBAND = 2
)
(
    input  logic [PW-1:0] cur_i,
    input  logic [PW-1:0] target_i,
    output logic [PW-1:0] dist_o,
    output logic          move_o,
    output logic [PW-1:0] next_o
);

    logic [PW-1:0] fwd;
    logic [PW-1:0] bwd;
    logic [PW-1:0] step;
    logic          up;

    // Pick the shorter way round (upward on an exact half-ring tie) and step
    // a fraction of the distance, never less than one, wrapping freely.
    always_comb begin
        fwd    = target_i - cur_i;
        bwd    = cur_i - target_i;
        up     = (fwd <= bwd);
        dist_o = PW'(circ_dist(CALC_W'(cur_i), CALC_W'(target_i), PW));
        step   = dist_o >> STEP_SH;
        if (step == '0) begin
            step = PW'(1);
        end
        move_o = (int'(dist_o) > DEADBAND);
        next_o = cur_i;
        if (move_o) begin
            next_o = up ? (cur_i + step) : (cur_i - step);
        end
    end

endmodule

// File: rtl/wta_seq_predictor_n.sv
// Winner-take-all phase predictor: slots track observed phases, and a
// slot-to-slot weight matrix learns which winner tends to follow which,
// giving a predicted next phase after every evaluation.
module wta_seq_predictor_n
    import pst_pkg::*;
#(
    parameter  int N_SLOTS    = 4,
    parameter  int PW         = PHASE_W_DEF,
    parameter  int WW         = WEIGHT_W_DEF,
    parameter  int NOVELTY_TH = 32,
    parameter  int DEADBAND   = 2,
    parameter  int STEP_SH    = 2,
    parameter  int ETA_LTP    = 4,
    parameter  int ETA_LTD    = 1,
    localparam int SW         = $clog2(N_SLOTS)
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic          cycle_start,
    input  logic          fired,
    input  logic [PW-1:0] actual_phase,
    output logic          busy,
    output logic          overrun,
    output logic          pred_valid,
    output logic [PW-1:0] pred_next,
    output logic [WW-1:0] pred_conf,
    output logic [PW-1:0] error_out,
    output logic          error_valid,
    output logic [SW-1:0] winner_out,
    output logic          recruited
);

    localparam int FW   = 2 * SW;
    localparam int LAST = N_SLOTS - 1;

    state_e        state_q, state_d;
    logic [SW-1:0] idx_q, idx_d;
    logic [PW-1:0] phase_q, phase_d;

    logic          min_found_q, min_found_d;
    logic [SW-1:0] min_idx_q, min_idx_d;
    logic [PW-1:0] min_dist_q, min_dist_d;

    logic          best_found_q, best_found_d;
    logic [SW-1:0] best_idx_q, best_idx_d;
    logic [WW-1:0] best_w_q, best_w_d;

    logic [PW-1:0]      slot_q [N_SLOTS];
    logic [PW-1:0]      slot_d [N_SLOTS];
    logic [N_SLOTS-1:0] used_q, used_d;
    logic [WW-1:0]      w_q [N_SLOTS*N_SLOTS];
    logic [WW-1:0]      w_d [N_SLOTS*N_SLOTS];
    logic [SW-1:0]      prev_q, prev_d;
    logic               prev_valid_q, prev_valid_d;

    logic          overrun_q, overrun_d;
    logic          pred_valid_q, pred_valid_d;
    logic [PW-1:0] pred_next_q, pred_next_d;
    logic [WW-1:0] pred_conf_q, pred_conf_d;
    logic [PW-1:0] error_q, error_d;
    logic          error_valid_q, error_valid_d;
    logic [SW-1:0] winner_q, winner_d;
    logic          recruited_q, recruited_d;

    logic          is_last;
    logic [PW-1:0] scan_dist;
    logic          free_found;
    logic [SW-1:0] free_idx;
    logic [PW-1:0] step_dist;
    logic          step_move;
    logic [PW-1:0] step_next;
    logic          recruit;
    logic [SW-1:0] win;
    logic [FW-1:0] row_ix;
    logic [WW-1:0] cand_w;
    logic          cand;
    logic          take;

    function automatic logic [WW-1:0] sat_inc(input logic [WW-1:0] v);
        logic [WW:0] s;
        s = {1'b0, v} + (WW+1)'(ETA_LTP);
        return s[WW] ? {WW{1'b1}} : s[WW-1:0];
    endfunction

    function automatic logic [WW-1:0] floor_dec(input logic [WW-1:0] v);
        return (v < WW'(ETA_LTD)) ? '0 : (v - WW'(ETA_LTD));
    endfunction

    assign is_last   = (idx_q == SW'(LAST));
    assign scan_dist = PW'(circ_dist(CALC_W'(slot_q[idx_q]), CALC_W'(phase_q), PW));
    assign row_ix    = {prev_q, idx_q};
    assign cand_w    = w_q[row_ix];
    assign cand      = used_q[idx_q] && (idx_q != prev_q);
    assign take      = cand && (!best_found_q || (cand_w > best_w_q));
    assign recruit   = !min_found_q || ((int'(min_dist_q) > NOVELTY_TH) && free_found);
    assign win       = recruit ? free_idx : min_idx_q;

    pst_circ_stepper #(
        .PW       (PW),
        .STEP_SH  (STEP_SH),
        .DEADBAND (DEADBAND)
    ) u_stepper (
        .cur_i    (slot_q[min_idx_q]),
        .target_i (phase_q),
        .dist_o   (step_dist),
        .move_o   (step_move),
        .next_o   (step_next)
    );

    // Lowest-index unused slot, the recruitment target.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int k = N_SLOTS - 1; k >= 0; k--) begin
            if (!used_q[SW'(k)]) begin
                free_found = 1'b1;
                free_idx   = SW'(k);
            end
        end
    end

    // Controller next state plus every datapath next value.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path can infer a latch.
        state_d       = state_q;
        idx_d         = idx_q;
        phase_d       = phase_q;
        min_found_d   = min_found_q;
        min_idx_d     = min_idx_q;
        min_dist_d    = min_dist_q;
        best_found_d  = best_found_q;
        best_idx_d    = best_idx_q;
        best_w_d      = best_w_q;
        slot_d        = slot_q;
        used_d        = used_q;
        w_d           = w_q;
        prev_d        = prev_q;
        prev_valid_d  = prev_valid_q;
        overrun_d     = cycle_start && (state_q != ST_IDLE);
        pred_valid_d  = 1'b0;
        pred_next_d   = pred_next_q;
        pred_conf_d   = pred_conf_q;
        error_d       = error_q;
        error_valid_d = error_valid_q;
        winner_d      = winner_q;
        recruited_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cycle_start) begin
                    phase_d      = actual_phase;
                    idx_d        = '0;
                    best_found_d = 1'b0;
                    if (fired) begin
                        min_found_d = 1'b0;
                        state_d     = ST_DSCAN;
                    end else begin
                        error_valid_d = 1'b0;
                        state_d       = ST_PSCAN;
                    end
                end
            end

            ST_DSCAN: begin
                if (used_q[idx_q] && (!min_found_q || (scan_dist < min_dist_q))) begin
                    min_found_d = 1'b1;
                    min_idx_d   = idx_q;
                    min_dist_d  = scan_dist;
                end
                idx_d = idx_q + SW'(1);
                if (is_last) begin
                    state_d = ST_LEARN;
                end
            end

            ST_LEARN: begin
                if (recruit) begin
                    slot_d[win]   = phase_q;
                    used_d[win]   = 1'b1;
                    recruited_d   = 1'b1;
                    error_d       = '0;
                    error_valid_d = 1'b0;
                end else begin
                    if (step_move) begin
                        slot_d[win] = step_next;
                    end
                    error_d       = step_dist;
                    error_valid_d = step_move;
                end
                if (prev_valid_q && (prev_q != win)) begin
                    for (int k = 0; k < N_SLOTS; k++) begin
                        if (SW'(k) == win) begin
                            w_d[{prev_q, SW'(k)}] = sat_inc(w_q[{prev_q, SW'(k)}]);
                        end else if (SW'(k) != prev_q) begin
                            w_d[{prev_q, SW'(k)}] = floor_dec(w_q[{prev_q, SW'(k)}]);
                        end
                    end
                end
                prev_d       = win;
                prev_valid_d = 1'b1;
                winner_d     = win;
                idx_d        = '0;
                best_found_d = 1'b0;
                state_d      = ST_PSCAN;
            end

            ST_PSCAN: begin
                if (take) begin
                    best_found_d = 1'b1;
                    best_idx_d   = idx_q;
                    best_w_d     = cand_w;
                end
                idx_d = idx_q + SW'(1);
                if (is_last) begin
                    state_d      = ST_DONE;
                    pred_valid_d = 1'b1;
                    if (best_found_d) begin
                        pred_next_d = slot_q[best_idx_d];
                        pred_conf_d = best_w_d;
                    end else begin
                        pred_next_d = slot_q[prev_q];
                        pred_conf_d = '0;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath, learned state and registered outputs; reset wipes any partial update.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            idx_q         <= '0;
            phase_q       <= '0;
            min_found_q   <= 1'b0;
            min_idx_q     <= '0;
            min_dist_q    <= '0;
            best_found_q  <= 1'b0;
            best_idx_q    <= '0;
            best_w_q      <= '0;
            // NOTE: slots and weights hold learned state with defined start values, so they are reset.
            for (int k = 0; k < N_SLOTS; k++) begin
                slot_q[SW'(k)] <= PW'(k) << (PW - SW);
            end
            for (int i = 0; i < N_SLOTS; i++) begin
                for (int j = 0; j < N_SLOTS; j++) begin
                    w_q[{SW'(i), SW'(j)}] <= (i == j) ? '0 : WW'(1);
                end
            end
            used_q        <= '0;
            prev_q        <= '0;
            prev_valid_q  <= 1'b0;
            overrun_q     <= 1'b0;
            pred_valid_q  <= 1'b0;
            pred_next_q   <= '0;
            pred_conf_q   <= '0;
            error_q       <= '0;
            error_valid_q <= 1'b0;
            winner_q      <= '0;
            recruited_q   <= 1'b0;
        end else begin
            idx_q         <= idx_d;
            phase_q       <= phase_d;
            min_found_q   <= min_found_d;
            min_idx_q     <= min_idx_d;
            min_dist_q    <= min_dist_d;
            best_found_q  <= best_found_d;
            best_idx_q    <= best_idx_d;
            best_w_q      <= best_w_d;
            slot_q        <= slot_d;
            w_q           <= w_d;
            used_q        <= used_d;
            prev_q        <= prev_d;
            prev_valid_q  <= prev_valid_d;
            overrun_q     <= overrun_d;
            pred_valid_q  <= pred_valid_d;
            pred_next_q   <= pred_next_d;
            pred_conf_q   <= pred_conf_d;
            error_q       <= error_d;
            error_valid_q <= error_valid_d;
            winner_q      <= winner_d;
            recruited_q   <= recruited_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign overrun     = overrun_q;
    assign pred_valid  = pred_valid_q;
    assign pred_next   = pred_next_q;
    assign pred_conf   = pred_conf_q;
    assign error_out   = error_q;
    assign error_valid = error_valid_q;
    assign winner_out  = winner_q;
    assign recruited   = recruited_q;

endmodule

// File: tb/tb_wta_seq_predictor_n.sv
// Self-checking bench for wta_seq_predictor_n (4 slots, 8-bit phase/weights).
module tb_wta_seq_predictor_n;

    localparam int N   = 4;
    localparam int NOV = 32;
    localparam int DB  = 2;
    localparam int SH  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cycle_start = 1'b0;
    logic       fired = 1'b0;
    logic [7:0] actual_phase = 8'd0;
    logic       busy, overrun, pred_valid, error_valid, recruited;
    logic [7:0] pred_next, pred_conf, error_out;
    logic [1:0] winner_out;

    wta_seq_predictor_n #(
        .N_SLOTS(4), .PW(8), .WW(8), .NOVELTY_TH(32), .DEADBAND(2),
        .STEP_SH(2), .ETA_LTP(4), .ETA_LTD(1)
    ) dut (
        .clk(clk), .rst(rst), .cycle_start(cycle_start), .fired(fired),
        .actual_phase(actual_phase), .busy(busy), .overrun(overrun),
        .pred_valid(pred_valid), .pred_next(pred_next), .pred_conf(pred_conf),
        .error_out(error_out), .error_valid(error_valid),
        .winner_out(winner_out), .recruited(recruited)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Behavioural model state.
    int m_slot [N];
    bit m_used [N];
    int m_w [N][N];
    int m_prev, m_err, m_win;
    bit m_pv, m_ev;

    // Expectations for the evaluation in flight.
    int exp_next, exp_conf, exp_err, exp_ev, exp_win, exp_rec, exp_lat, exp_ovr;
    // Compare-process bookkeeping and captured results.
    bit armed = 1'b0;
    bit done_flag = 1'b0;
    int lat, rec_cnt, ovr_cnt;
    int cap_next, cap_conf, cap_err, cap_ev, cap_lat, cap_rec;
    int centers [4] = '{20, 90, 160, 230};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, want);
        end
    endtask

    function automatic int cdist(input int a, input int b);
        int f, r;
        f = (a - b) & 255;
        r = (b - a) & 255;
        return (f < r) ? f : r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_slot[k] = k * 256 / N;
            m_used[k] = 1'b0;
            for (int j = 0; j < N; j++) m_w[k][j] = (k == j) ? 0 : 1;
        end
        m_prev = 0; m_pv = 1'b0; m_err = 0; m_ev = 1'b0; m_win = 0;
    endtask

    // Apply one evaluation to the model and derive every expected output.
    task automatic model_step(input bit f, input int ph);
        int best, bd, win, d, step, firstfree, bv;
        if (f) begin
            best = -1; bd = 0; firstfree = -1;
            for (int k = 0; k < N; k++) begin
                if (m_used[k]) begin
                    d = cdist(ph, m_slot[k]);
                    if (best < 0 || d < bd) begin best = k; bd = d; end
                end else if (firstfree < 0) begin
                    firstfree = k;
                end
            end
            if (best < 0 || (bd > NOV && firstfree >= 0)) begin
                win = firstfree;
                m_slot[win] = ph; m_used[win] = 1'b1;
                exp_rec = 1; m_err = 0; m_ev = 1'b0;
            end else begin
                win = best; exp_rec = 0; m_err = bd; m_ev = (bd > DB);
                if (bd > DB) begin
                    step = bd >> SH;
                    if (step < 1) step = 1;
                    if (((ph - m_slot[win]) & 255) == bd) m_slot[win] = (m_slot[win] + step) & 255;
                    else m_slot[win] = (m_slot[win] - step) & 255;
                end
            end
            if (m_pv && m_prev != win) begin
                for (int k = 0; k < N; k++) begin
                    if (k == win) m_w[m_prev][k] = (m_w[m_prev][k] + 4 > 255) ? 255 : m_w[m_prev][k] + 4;
                    else if (k != m_prev) m_w[m_prev][k] = (m_w[m_prev][k] > 0) ? m_w[m_prev][k] - 1 : 0;
                end
            end
            m_prev = win; m_pv = 1'b1; m_win = win;
            exp_lat = 2 * N + 2;
        end else begin
            m_ev = 1'b0; exp_rec = 0;
            exp_lat = N + 1;
        end
        best = -1; bv = 0;
        for (int k = 0; k < N; k++) begin
            if (k != m_prev && m_used[k] && (best < 0 || m_w[m_prev][k] > bv)) begin
                best = k; bv = m_w[m_prev][k];
            end
        end
        exp_next = (best < 0) ? m_slot[m_prev] : m_slot[best];
        exp_conf = (best < 0) ? 0 : bv;
        exp_err = m_err; exp_ev = m_ev; exp_win = m_win;
    endtask

    // Compare process: checks each prediction result against the model.
    always @(negedge clk) begin
        if (armed) begin
            if (recruited) rec_cnt++;
            if (overrun) ovr_cnt++;
            if (pred_valid) begin
                check("latency", lat, exp_lat);
                check("pred_next", pred_next, exp_next);
                check("pred_conf", pred_conf, exp_conf);
                check("error_out", error_out, exp_err);
                check("error_valid", error_valid, exp_ev);
                check("winner_out", winner_out, exp_win);
                check("recruited_pulses", rec_cnt, exp_rec);
                check("overrun_pulses", ovr_cnt, exp_ovr);
                cap_next = pred_next; cap_conf = pred_conf; cap_err = error_out;
                cap_ev = error_valid; cap_lat = lat; cap_rec = rec_cnt;
                armed = 1'b0; done_flag = 1'b1;
            end
            lat++;
        end
    end

    // One evaluation; ovr_at > 0 raises cycle_start again that many cycles later.
    task automatic eval(input bit f, input int ph, input int ovr_at);
        bit ok;
        model_step(f, ph);
        exp_ovr = (ovr_at > 0) ? 1 : 0;
        @(posedge clk); #1;
        cycle_start = 1'b1; fired = f; actual_phase = 8'(ph);
        lat = 0; rec_cnt = 0; ovr_cnt = 0; done_flag = 1'b0; armed = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            if (done_flag) begin ok = 1'b1; break; end
            #1;
            cycle_start  = (c + 1 == ovr_at);
            fired        = 1'($urandom_range(0, 1));
            actual_phase = 8'($urandom);
        end
        cycle_start = 1'b0;
        if (!ok) begin
            check("pred_valid_timeout", 0, 1);
            armed = 1'b0;
        end
        @(negedge clk);
        check("pulse_end", {pred_valid, busy}, 0);
    endtask

    task automatic check_reset_state(input string p);
        check({p, "_busy"}, busy, 0);
        check({p, "_pulses"}, {overrun, pred_valid, recruited, error_valid}, 0);
        check({p, "_outs"}, {pred_next, pred_conf, error_out, 6'd0, winner_out}, 0);
        check({p, "_used"}, dut.used_q, 0);
        check({p, "_prev_valid"}, dut.prev_valid_q, 0);
        for (int k = 0; k < N; k++) begin
            check($sformatf("%s_slot%0d", p, k), dut.slot_q[k], k * 64);
            for (int j = 0; j < N; j++)
                check($sformatf("%s_w%0d%0d", p, k, j), dut.w_q[k * N + j], (k == j) ? 0 : 1);
        end
    endtask

    task automatic do_reset();
        armed = 1'b0;
        @(posedge clk); #1 rst = 1'b1; cycle_start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        @(posedge clk); #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic reset_mid_scan(input int ph);
        @(posedge clk); #1 cycle_start = 1'b1; fired = 1'b1; actual_phase = 8'(ph);
        @(posedge clk); #1 cycle_start = 1'b0;
        @(posedge clk); #1;
        check("midscan_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_state("midrst");
        @(posedge clk); #1 rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int ph, ov;
        bit f;
        model_reset();
        do_reset();

        // First fired event recruits slot 0; no other candidate to predict.
        eval(1'b1, 40, 0);
        check("r36_lat", cap_lat, 10);
        check("r36_rec", cap_rec, 1);
        check("r36_next", cap_next, 40);
        check("r36_conf", cap_conf, 0);
        check("r36_slot0", dut.slot_q[0], 40);

        // Alternate 1/40 twelve times: both transitions reinforced six times.
        for (int i = 0; i < 12; i++) eval(1'b1, (i % 2 == 0) ? 1 : 40, 0);
        check("r37_next", cap_next, 1);
        check("r37_conf", cap_conf, 25);
        check("r37_w01", dut.w_q[1], 25);
        check("r37_w10", dut.w_q[4], 25);
        check("r37_slot1", dut.slot_q[1], 1);

        // Non-fired evaluation: short latency, error_valid cleared.
        eval(1'b0, 200, 0);
        check("r26_lat", cap_lat, 5);
        check("r29_ev", cap_ev, 0);
        check("r26_next", cap_next, 1);

        // Overrun during the distance scan is dropped.
        eval(1'b1, 1, 2);
        check("r40_next", cap_next, 40);
        check("r40_conf", cap_conf, 25);

        // Wrap-around move of slot 0 from 254 by step 2.
        do_reset();
        eval(1'b1, 254, 0);
        eval(1'b1, 6, 0);
        check("r38_slot0", dut.slot_q[0], 0);
        check("r38_err", cap_err, 8);
        check("r38_ev", cap_ev, 1);

        // Abort mid-scan.
        reset_mid_scan(99);

        // Weight saturation without wrap.
        for (int i = 0; i < 70; i++) begin
            eval(1'b1, 10, 0);
            eval(1'b1, 138, 0);
        end
        eval(1'b1, 10, 0);
        check("r39_conf", cap_conf, 255);
        check("r39_w01", dut.w_q[1], 255);
        check("r39_w02", dut.w_q[2], 0);
        check("r39_w03", dut.w_q[3], 0);

        // Randomized evaluations around phase clusters, with overruns and a mid-run abort.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            f = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) ph = int'($urandom_range(0, 255));
            else ph = (centers[$urandom_range(0, 3)] + int'($urandom_range(0, 24)) - 12) & 255;
            ov = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
            if (i == 150) reset_mid_scan(ph);
            eval(f, ph, ov);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
